rvh_l2_ar_responder: RTL and testbench

RVH_L2_AR_RESPONDER -- requirements
Module: rvh_l2_ar_responder

---
 rtl/rvh_l2_ar_responder_if.sv | 31 +++
 rtl/rvh_l2_ar_responder.sv | 155 +++++++++++++++
 tb/tb_rvh_l2_ar_responder.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvh_l2_ar_responder_if.sv
// AXI read-address and read-data channel bundle between the L1D and
// the L2 AR responder.
interface rvh_l2_ar_responder_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 56,
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/rvh_l2_ar_responder.sv
// L2 read responder: queues AR requests and returns one beat at a time
// from a single-cycle-latency backing store, SLVERR for unsupported bursts.
module rvh_l2_ar_responder #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 56,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rvh_l2_ar_responder_if.slave axi,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [DATA_W-1:0]    mem_rd_data
);
  localparam int BW_L = $clog2(DATA_W / 8);
  localparam int PW   = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_t;

  typedef enum logic [1:0] {IDLE, RD, DATA, RESP} state_t;

  ar_t           fifo_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   cnt_q;
  ar_t           ar_in;
  ar_t           head;
  logic          push;
  logic          pop;
  logic          head_err;

  state_t            state_q;
  state_t            state_n;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt;
  logic [2:0]        size_q;
  logic              fixed_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              last;
  logic              beat_adv;
  logic [ADDR_W-1:0] beat_addr;

  assign axi.arready = (cnt_q != (PW+1)'(DEPTH));
  assign push        = axi.arvalid & axi.arready;
  assign ar_in       = {axi.arid, axi.araddr, axi.arlen,
                        axi.arsize, axi.arburst};
  assign head        = fifo_q[rptr_q];
  assign head_err    = head.burst[1] | (head.size > 3'(BW_L));

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= ar_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign last     = (beat_cnt == len_q);
  assign beat_adv = (state_q == RESP) & axi.rready & ~last;

  // INCR wraps modulo 2^ADDR_W through the natural adder overflow
  assign beat_addr   = fixed_q ? base_q
                     : base_q + (ADDR_W'(beat_cnt) << size_q);
  assign mem_rd_addr = beat_addr & ~ADDR_W'(DATA_W / 8 - 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    pop       = 1'b0;
    mem_rd_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_n = head_err ? RESP : RD;
        end
      end
      RD: begin
        mem_rd_en = 1'b1;
        state_n   = DATA;
      end
      DATA: state_n = RESP;
      RESP: begin
        if (axi.rready) begin
          if (last)       state_n = IDLE;
          else if (err_q) state_n = RESP;
          else            state_n = RD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= '0;
      base_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      beat_cnt <= '0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      if (pop) begin
        id_q     <= head.id;
        base_q   <= head.addr
                  & ~((ADDR_W'(1) << head.size) - ADDR_W'(1));
        len_q    <= head.len;
        size_q   <= head.size;
        fixed_q  <= ~head.burst[0];
        err_q    <= head_err;
        beat_cnt <= '0;
        rdata_q  <= '0;
        rresp_q  <= head_err ? 2'b10 : 2'b00;
      end
      if (state_q == DATA) rdata_q <= mem_rd_data;
      if (beat_adv) beat_cnt <= beat_cnt + 8'd1;
    end
  end

  assign axi.rvalid = (state_q == RESP);
  assign axi.rlast  = (state_q == RESP) & last;
  assign axi.rid    = id_q;
  assign axi.rdata  = rdata_q;
  assign axi.rresp  = rresp_q;
endmodule

// File: tb/tb_rvh_l2_ar_responder.sv
// Directed bench for rvh_l2_ar_responder: latency, backpressure, FIFO
// full, error bursts, wrap/FIXED addressing and mid-burst reset.
module tb_rvh_l2_ar_responder;
  localparam int ID_W   = 8;
  localparam int ADDR_W = 56;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  rvh_l2_ar_responder_if #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) axi ();

  rvh_l2_ar_responder #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .axi        (axi),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    int                c;
  } beat_t;

  beat_t             rq[$];
  logic [ADDR_W-1:0] mq[$];
  int                art[$];
  beat_t             mb;
  logic              pend_en   = 1'b0;
  logic [ADDR_W-1:0] pend_addr = '0;

  function automatic logic [DATA_W-1:0] dat(input logic [ADDR_W-1:0] a);
    return {8'hD0, a};
  endfunction

  // backing store: data appears the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= pend_en ? dat(pend_addr) : 64'hBADB_ADBA_DBAD_BAD0;
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && axi.arvalid && axi.arready) art.push_back(cyc);
    if (rst === 1'b0 && axi.rvalid && axi.rready) begin
      mb.id   = axi.rid;
      mb.data = axi.rdata;
      mb.resp = axi.rresp;
      mb.last = axi.rlast;
      mb.c    = cyc;
      rq.push_back(mb);
    end
    if (mem_rd_en === 1'b1) mq.push_back(mem_rd_addr);
    pend_en   = (mem_rd_en === 1'b1);
    pend_addr = mem_rd_addr;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic clear_logs();
    rq.delete();
    mq.delete();
    art.delete();
  endtask

  task automatic idle_ar();
    axi.arvalid = 1'b0;
    axi.arid    = '0;
    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arsize  = '0;
    axi.arburst = '0;
  endtask

  task automatic drive_ar(input logic [7:0] id, input logic [ADDR_W-1:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bu);
    axi.arvalid = 1'b1;
    axi.arid    = id;
    axi.araddr  = a;
    axi.arlen   = len;
    axi.arsize  = sz;
    axi.arburst = bu;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [ADDR_W-1:0] a,
                         input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu);
    bit ok = 0;
    drive_ar(id, a, len, sz, bu);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (axi.arready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ar_accept id=%h: arready never high", id);
    end
    @(posedge clk);
    #1;
    idle_ar();
  endtask

  task automatic wait_beats(input int n, input string nm);
    for (int k = 0; k < 300; k++) begin
      if (rq.size() >= n) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (rq.size() != n) begin
      errors++;
      $display("FAIL %s beat_count: got %0d want %0d", nm, rq.size(), n);
    end
  endtask

  task automatic wait_rvalid(input string nm);
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (axi.rvalid === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s rvalid_timeout: rvalid never rose", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_ar();
    axi.rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 7;
    if (axi.rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_rvalid got %b want 0", axi.rvalid);
    end
    if (axi.rlast !== 1'b0) begin
      errors++; $display("FAIL rst_rlast got %b want 0", axi.rlast);
    end
    if (mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL rst_mem_rd_en got %b want 0", mem_rd_en);
    end
    if (axi.rresp !== 2'b00) begin
      errors++; $display("FAIL rst_rresp got %b want 00", axi.rresp);
    end
    if (axi.rdata !== '0) begin
      errors++; $display("FAIL rst_rdata got %h want 0", axi.rdata);
    end
    if (axi.rid !== '0) begin
      errors++; $display("FAIL rst_rid got %h want 0", axi.rid);
    end
    if (axi.arready !== 1'b1) begin
      errors++; $display("FAIL rst_arready got %b want 1", axi.arready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_incr4();
    logic [ADDR_W-1:0] ea;
    clear_logs();
    axi.rready = 1'b1;
    send_ar(8'h05, 56'h1000, 8'd3, 3'd3, 2'b01);
    wait_beats(4, "incr4");
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      ea = 56'h1000 + ADDR_W'(i * 8);
      checks += 4;
      if (rq[i].id !== 8'h05) begin
        errors++; $display("FAIL incr4_rid[%0d] got %h want 05", i, rq[i].id);
      end
      if (rq[i].resp !== 2'b00) begin
        errors++; $display("FAIL incr4_rresp[%0d] got %b want 00", i, rq[i].resp);
      end
      if (rq[i].last !== (i == 3)) begin
        errors++; $display("FAIL incr4_rlast[%0d] got %b", i, rq[i].last);
      end
      if (rq[i].data !== dat(ea)) begin
        errors++; $display("FAIL incr4_rdata[%0d] got %h want %h", i, rq[i].data, dat(ea));
      end
      if (i > 0) begin
        checks++;
        if (rq[i].c - rq[i-1].c !== 3) begin
          errors++; $display("FAIL incr4_spacing[%0d] got %0d want 3", i, rq[i].c - rq[i-1].c);
        end
      end
    end
    checks++;
    if (mq.size() != 4) begin
      errors++; $display("FAIL incr4_rd_count got %0d want 4", mq.size());
    end
    for (int i = 0; i < 4 && i < mq.size(); i++) begin
      ea = 56'h1000 + ADDR_W'(i * 8);
      checks++;
      if (mq[i] !== ea) begin
        errors++; $display("FAIL incr4_rd_addr[%0d] got %h want %h", i, mq[i], ea);
      end
    end
    if (art.size() > 0 && rq.size() > 0) begin
      checks++;
      if (rq[0].c - art[0] !== 4) begin
        errors++; $display("FAIL incr4_latency got %0d want 4", rq[0].c - art[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit stable = 1;
    bit no_rd  = 1;
    logic [ADDR_W-1:0] ea;
    clear_logs();
    axi.rready = 1'b0;
    send_ar(8'h22, 56'h2000, 8'd3, 3'd3, 2'b01);
    wait_rvalid("bp_beat1");
    @(posedge clk); #1; axi.rready = 1'b1;
    @(posedge clk); #1; axi.rready = 1'b0;
    wait_rvalid("bp_beat2");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (axi.rvalid !== 1'b1 || axi.rid !== 8'h22 || axi.rlast !== 1'b0 ||
          axi.rdata !== dat(56'h2008)) stable = 0;
      if (mq.size() != 2) no_rd = 0;
    end
    checks += 3;
    if (!stable) begin
      errors++; $display("FAIL bp_hold got rdata=%h rid=%h rlast=%b want %h 22 0",
                         axi.rdata, axi.rid, axi.rlast, dat(56'h2008));
    end
    if (!no_rd) begin
      errors++; $display("FAIL bp_no_mem_rd got %0d reads want 2", mq.size());
    end
    if (rq.size() != 1) begin
      errors++; $display("FAIL bp_stall_beats got %0d want 1", rq.size());
    end
    @(posedge clk); #1; axi.rready = 1'b1;
    wait_beats(4, "bp");
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      ea = 56'h2000 + ADDR_W'(i * 8);
      checks += 2;
      if (rq[i].data !== dat(ea)) begin
        errors++; $display("FAIL bp_rdata[%0d] got %h want %h", i, rq[i].data, dat(ea));
      end
      if (rq[i].last !== (i == 3)) begin
        errors++; $display("FAIL bp_rlast[%0d] got %b", i, rq[i].last);
      end
    end
  endtask

  task automatic test_fifo_full();
    bit full = 1;
    bit ok   = 0;
    logic [7:0] eid;
    clear_logs();
    axi.rready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_ar(8'(i + 1), ADDR_W'((i + 1) * 256), 8'd0, 3'd3, 2'b01);
    drive_ar(8'h06, 56'h600, 8'd0, 3'd3, 2'b01);
    repeat (4) begin
      @(negedge clk);
      if (axi.arready !== 1'b0) full = 0;
    end
    checks += 2;
    if (!full) begin
      errors++; $display("FAIL full_arready got 1 want 0");
    end
    if (art.size() != 5) begin
      errors++; $display("FAIL full_accepted got %0d want 5", art.size());
    end
    @(posedge clk); #1; axi.rready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (axi.arready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL full_drain arready never returned");
    end
    @(posedge clk); #1; idle_ar();
    wait_beats(6, "full");
    for (int i = 0; i < 6 && i < rq.size(); i++) begin
      eid = 8'(i + 1);
      checks += 3;
      if (rq[i].id !== eid) begin
        errors++; $display("FAIL full_order[%0d] got %h want %h", i, rq[i].id, eid);
      end
      if (rq[i].data !== dat(ADDR_W'((i + 1) * 256))) begin
        errors++; $display("FAIL full_rdata[%0d] got %h", i, rq[i].data);
      end
      if (rq[i].last !== 1'b1) begin
        errors++; $display("FAIL full_rlast[%0d] got 0 want 1", i);
      end
    end
  endtask

  task automatic test_error();
    logic [1:0] bu;
    logic [2:0] sz;
    axi.rready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      clear_logs();
      bu = (c == 0) ? 2'b10 : 2'b01;
      sz = (c == 0) ? 3'd3 : 3'd4;
      send_ar(8'h33, 56'h3000, 8'd1, sz, bu);
      wait_beats(2, "err");
      for (int i = 0; i < 2 && i < rq.size(); i++) begin
        checks += 4;
        if (rq[i].resp !== 2'b10) begin
          errors++; $display("FAIL err%0d_rresp[%0d] got %b want 10", c, i, rq[i].resp);
        end
        if (rq[i].data !== '0) begin
          errors++; $display("FAIL err%0d_rdata[%0d] got %h want 0", c, i, rq[i].data);
        end
        if (rq[i].id !== 8'h33) begin
          errors++; $display("FAIL err%0d_rid[%0d] got %h want 33", c, i, rq[i].id);
        end
        if (rq[i].last !== (i == 1)) begin
          errors++; $display("FAIL err%0d_rlast[%0d] got %b", c, i, rq[i].last);
        end
      end
      checks++;
      if (mq.size() != 0) begin
        errors++; $display("FAIL err%0d_mem_rd got %0d want 0", c, mq.size());
      end
      if (art.size() > 0 && rq.size() > 0) begin
        checks++;
        if (rq[0].c - art[0] !== 2) begin
          errors++; $display("FAIL err%0d_latency got %0d want 2", c, rq[0].c - art[0]);
        end
      end
    end
  endtask

  task automatic test_wrap_fixed();
    logic [ADDR_W-1:0] va [3];
    logic [1:0]        vb [3];
    logic [2:0]        vs [3];
    int                vn [3];
    logic [ADDR_W-1:0] ex [3][3];
    va[0] = 56'hFF_FFFF_FFFF_FFF8; vb[0] = 2'b01; vs[0] = 3'd3; vn[0] = 2;
    va[1] = 56'h4010;              vb[1] = 2'b00; vs[1] = 3'd3; vn[1] = 3;
    va[2] = 56'h5004;              vb[2] = 2'b01; vs[2] = 3'd2; vn[2] = 3;
    ex[0][0] = 56'hFF_FFFF_FFFF_FFF8; ex[0][1] = 56'h0; ex[0][2] = 56'h0;
    ex[1][0] = 56'h4010; ex[1][1] = 56'h4010; ex[1][2] = 56'h4010;
    ex[2][0] = 56'h5000; ex[2][1] = 56'h5008; ex[2][2] = 56'h5008;
    axi.rready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      clear_logs();
      send_ar(8'(8'h50 + v), va[v], 8'(vn[v] - 1), vs[v], vb[v]);
      wait_beats(vn[v], "addr");
      checks++;
      if (mq.size() != vn[v]) begin
        errors++; $display("FAIL addr%0d_rd_count got %0d want %0d", v, mq.size(), vn[v]);
      end
      for (int i = 0; i < vn[v] && i < mq.size() && i < rq.size(); i++) begin
        checks += 3;
        if (mq[i] !== ex[v][i]) begin
          errors++; $display("FAIL addr%0d_rd_addr[%0d] got %h want %h", v, i, mq[i], ex[v][i]);
        end
        if (rq[i].data !== dat(ex[v][i])) begin
          errors++; $display("FAIL addr%0d_rdata[%0d] got %h want %h", v, i, rq[i].data, dat(ex[v][i]));
        end
        if (rq[i].last !== (i == vn[v] - 1)) begin
          errors++; $display("FAIL addr%0d_rlast[%0d] got %b", v, i, rq[i].last);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    axi.rready = 1'b0;
    send_ar(8'h44, 56'h6000, 8'd3, 3'd3, 2'b01);
    send_ar(8'h45, 56'h6800, 8'd0, 3'd3, 2'b01);
    wait_rvalid("rmid_beat1");
    @(posedge clk); #1; axi.rready = 1'b1;
    @(posedge clk); #1; axi.rready = 1'b0;
    wait_rvalid("rmid_beat2");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (axi.rvalid !== 1'b0) begin
      errors++; $display("FAIL rmid_rvalid got %b want 0", axi.rvalid);
    end
    if (axi.arready !== 1'b1) begin
      errors++; $display("FAIL rmid_arready got %b want 1", axi.arready);
    end
    @(posedge clk); #1; axi.rready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks += 2;
    if (rq.size() != 1) begin
      errors++; $display("FAIL rmid_flushed_beats got %0d want 1", rq.size());
    end
    if (mq.size() != 2) begin
      errors++; $display("FAIL rmid_flushed_reads got %0d want 2", mq.size());
    end
    clear_logs();
    send_ar(8'h46, 56'h7000, 8'd0, 3'd3, 2'b01);
    wait_beats(1, "rmid_new");
    if (rq.size() > 0 && art.size() > 0) begin
      checks += 4;
      if (rq[0].id !== 8'h46) begin
        errors++; $display("FAIL rmid_new_rid got %h want 46", rq[0].id);
      end
      if (rq[0].data !== dat(56'h7000)) begin
        errors++; $display("FAIL rmid_new_rdata got %h want %h", rq[0].data, dat(56'h7000));
      end
      if (rq[0].last !== 1'b1 || rq[0].resp !== 2'b00) begin
        errors++; $display("FAIL rmid_new_last_resp got %b/%b want 1/00", rq[0].last, rq[0].resp);
      end
      if (rq[0].c - art[0] !== 4) begin
        errors++; $display("FAIL rmid_new_latency got %0d want 4", rq[0].c - art[0]);
      end
    end
  endtask

  initial begin
    idle_ar();
    axi.rready = 1'b0;
    test_reset();
    test_incr4();
    test_backpressure();
    test_fifo_full();
    test_error();
    test_wrap_fixed();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
